// File: rtl/snake_input_pkg.sv
// Shared definitions for the snake game input path: direction encodings
// (also used by the navigation state machine), button bit positions and
// counter widths.
package snake_input_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int unsigned BTN_IDX_U = 3;
  localparam int unsigned BTN_IDX_D = 2;
  localparam int unsigned BTN_IDX_L = 1;
  localparam int unsigned BTN_IDX_R = 0;

  localparam int unsigned DBC_W = 24;
  localparam int unsigned RPT_W = 25;

  // Fixed priority U > D > L > R over a {U,D,L,R} pulse vector
  function automatic dir_t prio_dir(input logic [3:0] p);
    if (p[BTN_IDX_U])      return DIR_UP;
    else if (p[BTN_IDX_D]) return DIR_DOWN;
    else if (p[BTN_IDX_L]) return DIR_LEFT;
    else                   return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: SYNC_STAGES-deep synchroniser, saturating-free
// stability counter and accepted (stable) level. rise_next flags that the
// stable level goes 0->1 at the coming clock edge.
module debounce_channel
  import snake_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_next
);

  localparam logic [DBC_W-1:0] CNT_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBC_W-1:0]       cnt;
  logic                   sync;
  logic                   accept;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign accept    = (sync != level) && (cnt == CNT_LAST);
  assign rise_next = accept && sync;

  // Metastability synchroniser for the asynchronous raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (accept) begin
      level <= sync;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_input_conditioner.sv
// Conditions the four push-buttons and the START_STOP switch for the snake
// game: debounced levels, one-cycle press pulses and a priority-encoded
// direction request. Define AUTO_REPEAT_EN to re-fire pulses every
// REPEAT_CYCLES while a button is held.
module button_input_conditioner
  import snake_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNU_RAW,
  input  logic       BTND_RAW,
  input  logic       BTNL_RAW,
  input  logic       BTNR_RAW,
  input  logic       START_STOP_RAW,
  output logic       BTNU,
  output logic       BTND,
  output logic       BTNL,
  output logic       BTNR,
  output logic       START_STOP,
  output logic [3:0] BTN_PULSE,
  output logic       DIR_REQ_VALID,
  output logic [1:0] DIR_REQ
);

  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;
  logic [3:0] pulse_next;
  logic       ss_rise;

  assign btn_raw[BTN_IDX_U] = BTNU_RAW;
  assign btn_raw[BTN_IDX_D] = BTND_RAW;
  assign btn_raw[BTN_IDX_L] = BTNL_RAW;
  assign btn_raw[BTN_IDX_R] = BTNR_RAW;

  assign BTNU = btn_level[BTN_IDX_U];
  assign BTND = btn_level[BTN_IDX_D];
  assign BTNL = btn_level[BTN_IDX_L];
  assign BTNR = btn_level[BTN_IDX_R];

  for (genvar g = 0; g < 4; g++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan (
      .clk       (CLK),
      .rst       (RESET),
      .raw       (btn_raw[g]),
      .level     (btn_level[g]),
      .rise_next (btn_rise[g])
    );
  end

  // The switch is a level control only; its rise indication goes nowhere
  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_start_stop (
    .clk       (CLK),
    .rst       (RESET),
    .raw       (START_STOP_RAW),
    .level     (START_STOP),
    .rise_next (ss_rise)
  );

`ifdef AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt [4];
  logic [3:0]       rpt_fire;

  // Counter restarts at acceptance (level still 0 on that edge), so the
  // first repeat lands exactly REPEAT_CYCLES after the press pulse
  always_comb begin
    rpt_fire = '0;
    for (int unsigned i = 0; i < 4; i++)
      rpt_fire[i] = btn_level[i] && (rpt_cnt[i] == RPT_LAST);
  end

  // Per-button repeat period counters, cleared while released
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 4; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!btn_level[i] || rpt_fire[i]) rpt_cnt[i] <= '0;
        else                              rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
      end
    end
  end

  assign pulse_next = btn_rise | rpt_fire;
`else
  assign pulse_next = btn_rise;
`endif

  // Register pulses with the direction request so both align with the level change
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BTN_PULSE     <= '0;
      DIR_REQ_VALID <= 1'b0;
      DIR_REQ       <= '0;
    end else begin
      BTN_PULSE     <= pulse_next;
      DIR_REQ_VALID <= |pulse_next;
      if (|pulse_next) DIR_REQ <= prio_dir(pulse_next);
    end
  end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Self-checking bench for button_input_conditioner with short debounce and
// repeat periods.
module tb_button_input_conditioner;

  localparam int unsigned DBC  = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned RPT  = 20;
  localparam int unsigned LAT  = SYNC + DBC;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTNU_RAW = 1'b0, BTND_RAW = 1'b0, BTNL_RAW = 1'b0, BTNR_RAW = 1'b0;
  logic       START_STOP_RAW = 1'b0;
  logic       BTNU, BTND, BTNL, BTNR, START_STOP;
  logic [3:0] BTN_PULSE;
  logic       DIR_REQ_VALID;
  logic [1:0] DIR_REQ;

  button_input_conditioner #(
    .DEBOUNCE_CYCLES (DBC),
    .SYNC_STAGES     (SYNC),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BTNU_RAW       (BTNU_RAW),
    .BTND_RAW       (BTND_RAW),
    .BTNL_RAW       (BTNL_RAW),
    .BTNR_RAW       (BTNR_RAW),
    .START_STOP_RAW (START_STOP_RAW),
    .BTNU           (BTNU),
    .BTND           (BTND),
    .BTNL           (BTNL),
    .BTNR           (BTNR),
    .START_STOP     (START_STOP),
    .BTN_PULSE      (BTN_PULSE),
    .DIR_REQ_VALID  (DIR_REQ_VALID),
    .DIR_REQ        (DIR_REQ)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  pulse;
    logic [1:0]  dir;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [4:0] raw;    // {U,D,L,R,SS}
    logic [3:0] pulse;  // expected press pulse, 0 = none
    logic [1:0] dir;
    logic [4:0] lvl;    // expected debounced levels {U,D,L,R,SS}
    logic [1:0] dir_after;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic drive(input logic [4:0] r);
    {BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW, START_STOP_RAW} = r;
  endtask

  // Raw change at this negedge: next posedge is edge 0, pulse observed LAT cycles on
  task automatic expect_press(input logic [3:0] p, input logic [1:0] d, input int unsigned dly);
    exp_t e;
    e.cyc = cyc + LAT + dly;
    e.pulse = p;
    e.dir = d;
    sbq.push_back(e);
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [4:0] levels();
    return {BTNU, BTND, BTNL, BTNR, START_STOP};
  endfunction

  // Scoreboard: every pulse/strobe must match the oldest pending expectation
  always @(negedge CLK) begin
    if (!RESET && (BTN_PULSE != 4'd0 || DIR_REQ_VALID)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {27'd0, BTN_PULSE, DIR_REQ_VALID}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_cycle", e.cyc <= cyc ? cyc - e.cyc : 32'hFFFF, 32'd0);
        chk("btn_pulse", BTN_PULSE, e.pulse);
        chk("dir_valid", DIR_REQ_VALID, 1);
        chk("dir_req", DIR_REQ, e.dir);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'b00000, 4'b0000, 2'd0, 5'b00000, 2'd0};
    vecs[1] = '{5'b10000, 4'b1000, 2'd0, 5'b10000, 2'd0};
    vecs[2] = '{5'b11010, 4'b0101, 2'd1, 5'b11010, 2'd1};
    vecs[3] = '{5'b11011, 4'b0000, 2'd0, 5'b11011, 2'd1};
    vecs[4] = '{5'b01011, 4'b0000, 2'd0, 5'b01011, 2'd1};
    vecs[5] = '{5'b00000, 4'b0000, 2'd0, 5'b00000, 2'd1};
    vecs[6] = '{5'b10100, 4'b1010, 2'd0, 5'b10100, 2'd0};
    vecs[7] = '{5'b00000, 4'b0000, 2'd0, 5'b00000, 2'd0};
    vecs[8] = '{5'b00010, 4'b0001, 2'd3, 5'b00010, 2'd3};
    vecs[9] = '{5'b00000, 4'b0000, 2'd0, 5'b00000, 2'd3};

    wait_neg(3);
    chk("rst_levels", levels(), 5'b00000);
    chk("rst_pulse", BTN_PULSE, 4'd0);
    chk("rst_valid", DIR_REQ_VALID, 1'b0);
    chk("rst_dir", DIR_REQ, 2'd0);
    RESET = 1'b0;
    wait_neg(1);

`ifdef AUTO_REPEAT_EN
    // Held right button repeats every RPT cycles, nothing after release
    drive(5'b00010);
    for (int k = 0; k < 4; k++) expect_press(4'b0001, 2'd3, k * RPT);
    wait_neg(LAT + 60);
    drive(5'b00000);
    wait_neg(LAT + RPT + 5);
    chk("rpt_release_level", BTNR, 1'b0);
`else
    // Table of level patterns
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].raw);
      if (vecs[i].pulse != 4'd0) expect_press(vecs[i].pulse, vecs[i].dir, 0);
      wait_neg(LAT + 2);
      chk($sformatf("vec%0d_levels", i), levels(), vecs[i].lvl);
      chk($sformatf("vec%0d_dir_hold", i), DIR_REQ, vecs[i].dir_after);
    end

    // Exact acceptance latency on a clean press
    drive(5'b10000);
    expect_press(4'b1000, 2'd0, 0);
    wait_neg(LAT - 1);
    chk("lat_before", BTNU, 1'b0);
    wait_neg(1);
    chk("lat_at", BTNU, 1'b1);
    drive(5'b00000);
    wait_neg(LAT + 2);

    // Short glitches restart the count; only the final held rise is accepted
    for (int g = 0; g < 2; g++) begin
      drive(5'b00100);
      wait_neg(5);
      drive(5'b00000);
      wait_neg(1);
    end
    drive(5'b00100);
    expect_press(4'b0010, 2'd2, 0);
    wait_neg(LAT - 1);
    chk("glitch_before", BTNL, 1'b0);
    wait_neg(3);
    chk("glitch_level", BTNL, 1'b1);
    drive(5'b00000);
    wait_neg(LAT + 2);

    // Release latency, no pulse on release, direction held
    drive(5'b00010);
    expect_press(4'b0001, 2'd3, 0);
    wait_neg(LAT + 2);
    drive(5'b00000);
    wait_neg(LAT - 1);
    chk("rel_before", BTNR, 1'b1);
    wait_neg(1);
    chk("rel_at", BTNR, 1'b0);
    chk("rel_dir_hold", DIR_REQ, 2'd3);
    wait_neg(2);

    // Reset mid-count clears everything; count restarts from release
    drive(5'b10000);
    wait_neg(5);
    RESET = 1'b1;
    #1;
    chk("midrst_levels", levels(), 5'b00000);
    chk("midrst_dir", DIR_REQ, 2'd0);
    chk("midrst_valid", DIR_REQ_VALID, 1'b0);
    wait_neg(2);
    RESET = 1'b0;
    expect_press(4'b1000, 2'd0, 0);
    wait_neg(LAT - 1);
    chk("midrst_before", BTNU, 1'b0);
    wait_neg(1);
    chk("midrst_at", BTNU, 1'b1);
    drive(5'b00000);
    wait_neg(LAT + 2);
`endif

    chk("sb_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_input_conditioner.md
Name: button_input_conditioner

Overview:
Conditions the raw push-buttons and the START_STOP switch before they reach the snake game top level: synchronises, debounces, and produces clean levels, one-cycle press pulses and a single priority-encoded direction request. Sits directly upstream of the game top; its debounced levels drive the master and navigation state machines' BTNU/BTND/BTNL/BTNR and the controller's START_STOP.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); legal range 2 to 2^24-1
SYNC_STAGES, 2, flip-flops in each input synchroniser; legal values 2 or 3
REPEAT_CYCLES, 25000000, auto-repeat period; used only when AUTO_REPEAT_EN is defined

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
BTNU_RAW  in  1  raw up button, asynchronous to CLK
BTND_RAW  in  1  raw down button
BTNL_RAW  in  1  raw left button
BTNR_RAW  in  1  raw right button
START_STOP_RAW  in  1  raw slide switch
BTNU  out  1  debounced up level
BTND  out  1  debounced down level
BTNL  out  1  debounced left level
BTNR  out  1  debounced right level
START_STOP  out  1  debounced switch level
BTN_PULSE  out  4  one-cycle press pulses, bit order {U,D,L,R} = [3:0]
DIR_REQ_VALID  out  1  one-cycle strobe: a new direction press was accepted
DIR_REQ  out  2  requested direction, valid only with DIR_REQ_VALID

Behaviour:
- Reset: one clock, CLK; reset is asynchronous and active-high (RESET). All synchroniser flops, debounced levels, counters, BTN_PULSE, DIR_REQ_VALID and DIR_REQ clear to 0 immediately. After release, the first accepted press still needs the full SYNC_STAGES + DEBOUNCE_CYCLES.
- There are 5 identical channels, each with an SYNC_STAGES-deep synchroniser, a 24-bit counter and a stable level.
- Per-channel debounce, checked every cycle:
  - sync == stable: counter is set to 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable is set to sync and counter is set to 0.
  - Otherwise: counter increments.
  - Any glitch (sync returns to stable) restarts the count from 0. The counter never wraps.
- Latency: a raw level held from cycle 0 changes the stable output at cycle SYNC_STAGES+DEBOUNCE_CYCLES. A held pulse shorter than DEBOUNCE_CYCLES is never seen.
- BTN_PULSE[i]: registered and high for exactly one cycle, in the same cycle that the button's stable level goes 0->1. Releases produce no pulse. START_STOP has no pulse.
- Direction request: DIR_REQ_VALID = OR of BTN_PULSE, registered alongside it.
  - Direction encoding: 2'd0 up, 2'd1 down, 2'd2 left, 2'd3 right.
  - Simultaneous accepted presses use fixed priority U > D > L > R. Lower-priority presses in that same cycle are dropped, and their stable levels still assert.
  - DIR_REQ holds its last value when DIR_REQ_VALID is low.
- Holding a button produces no further pulses unless AUTO_REPEAT_EN is defined.
- Reset asserted mid-count discards all partial counts.

Optional Feature:
AUTO_REPEAT_EN
- Defined: for each of the 4 buttons there is a 25-bit repeat counter, started at the accepted press.
  - While the stable level stays 1, BTN_PULSE re-fires every REPEAT_CYCLES cycles, and so does DIR_REQ_VALID.
  - Priority still applies between buttons.
  - Release clears the counter.
- Undefined: the repeat counters are not built; exactly one pulse per press.

Decomposition:
- Package snake_input_pkg holds:
  - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, shared with the navigation state machine;
  - button index constants BTN_IDX_U=3, D=2, L=1, R=0;
  - the counter width constant DBC_W=24.
- One sub-module, debounce_channel (synchroniser + counter + stable level + rise pulse), instantiated 5 times. The top level adds priority encoding and the optional repeat logic.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, REPEAT_CYCLES=20):
- BTNU_RAW 0->1 at cycle 0 and held -> BTNU=1 from cycle 10; BTN_PULSE=4'b1000 and DIR_REQ_VALID=1 with DIR_REQ=0 for only cycle 10.
- BTNL_RAW with high glitches of 5 cycles separated by 1-cycle lows, then held -> no pulse until 10 cycles after the final rise; a single pulse DIR_REQ=2.
- BTND_RAW and BTNR_RAW rise together -> BTN_PULSE=4'b0101, DIR_REQ=1 (down wins), BTND=BTNR=1.
- BTNR held 10 cycles then released -> BTNR falls 10 cycles after the release; no pulse on release; DIR_REQ keeps 3.
- RESET asserted 5 cycles into a BTNU count, raw still high -> all outputs 0 at once; after release, BTNU rises 10 cycles later.
- AUTO_REPEAT_EN defined, BTNR held 70 cycles past acceptance -> pulses at acceptance+0, +20, +40, +60; none after release.
